wb_mailbox: RTL and testbench

WB_MAILBOX -- requirements
Module: wb_mailbox

---
 rtl/wb_mailbox_pkg.sv | 18 +
 rtl/wb_mailbox_if.sv | 18 +
 rtl/wb_mailbox_fifo.sv | 50 +++++
 rtl/wb_mailbox.sv | 126 ++++++++++++
 tb/tb_wb_mailbox.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_mailbox_pkg.sv
// wb_mailbox_pkg: register offsets and STATUS bit positions shared by the mailbox
// Contents:
//    reg_e        - register selector decoded from adr[3:2]
//    ST_*         - STATUS word field positions
package wb_mailbox_pkg;
   typedef enum logic [1:0] {
      REG_TXDATA = 2'd0,
      REG_RXDATA = 2'd1,
      REG_STATUS = 2'd2,
      REG_IRQ_EN = 2'd3
   } reg_e;
   localparam int ST_TX_EMPTY = 0;
   localparam int ST_TX_FULL  = 1;
   localparam int ST_RX_EMPTY = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_TX_CNT   = 8;
   localparam int ST_RX_CNT   = 16;
endpackage

// File: rtl/wb_mailbox_if.sv
// wb_if: Wishbone B4 pipelined bus bundle
// Signals:
//    cyc, stb, we, adr[31:0], sel[3:0], dat_i[31:0]  - initiator to responder
//    ack, err, stall, dat_o[31:0]                   - responder to initiator
interface wb_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack;
   logic        err;
   logic        stall;
   modport slave (input cyc, stb, we, adr, sel, dat_i, output ack, err, stall, dat_o);
   modport master (output cyc, stb, we, adr, sel, dat_i, input ack, err, stall, dat_o);
endinterface

// File: rtl/wb_mailbox_fifo.sv
// wb_mailbox_fifo: synchronous FIFO, DEPTH entries of WIDTH bits
// Ports:
//    clk, rst         - clock, asynchronous active-high reset
//    push_i, din_i    - write request and data (ignored when full)
//    pop_i            - read request (ignored when empty)
//    dout_o           - head word
//    full_o, empty_o  - occupancy flags
//    count_o          - entries held, 0..DEPTH
module wb_mailbox_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;
   assign full_o  = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_q];
   // Flags gate the requests so a full FIFO refuses push even when popped in the same cycle
   assign do_push = push_i & !full_o;
   assign do_pop  = pop_i & !empty_o;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/wb_mailbox.sv
// wb_mailbox: Wishbone mailbox with TX/RX stream FIFOs and level interrupt
// Ports:
//    clk, rst            - clock, asynchronous active-high reset
//    wb                  - Wishbone B4 pipelined responder (never stalls)
//    tx_valid/data/ready - TX stream out of the TX FIFO
//    rx_valid/data/ready - RX stream into the RX FIFO
//    irq                 - registered level interrupt
// Registers (adr[3:2]): 0 TXDATA W, 1 RXDATA R, 2 STATUS R, 3 IRQ_EN R/W
// Build option: WB_MAILBOX_IRQ_EN enables IRQ_EN and irq; otherwise irq=0 and IRQ_EN reads 0.
module wb_mailbox
   import wb_mailbox_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   wb_if.slave              wb,
   output logic             tx_valid,
   output logic [WIDTH-1:0] tx_data,
   input  logic             tx_ready,
   input  logic             rx_valid,
   input  logic [WIDTH-1:0] rx_data,
   output logic             rx_ready,
   output logic             irq
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic             ack_q, ack_d, err_q, err_d;
   logic [WIDTH-1:0] dat_q, dat_d;
   logic             tx_push, tx_full, tx_empty;
   logic             rx_pop, rx_full, rx_empty;
   logic [CW-1:0]    tx_count, rx_count;
   logic [WIDTH-1:0] rx_head;
   logic [WIDTH-1:0] status;
   logic             req;
   reg_e             reg_sel;
   logic             unused_ok;
   assign req       = wb.cyc & wb.stb;
   assign reg_sel   = reg_e'(wb.adr[3:2]);
   assign unused_ok = ^{wb.adr[31:4], wb.adr[1:0], wb.sel};
   assign wb.stall  = 1'b0;
   assign wb.ack    = ack_q;
   assign wb.err    = err_q;
   assign wb.dat_o  = dat_q;
   assign tx_valid  = !tx_empty;
   assign rx_ready  = !rx_full;
   wb_mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx (
      .clk(clk), .rst(rst), .push_i(tx_push), .din_i(wb.dat_i), .pop_i(tx_valid & tx_ready),
      .dout_o(tx_data), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
   );
   wb_mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx (
      .clk(clk), .rst(rst), .push_i(rx_valid), .din_i(rx_data), .pop_i(rx_pop),
      .dout_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
   );
   always_comb begin
      status = '0;
      status[ST_RX_CNT +: 8] = 8'(rx_count);
      status[ST_TX_CNT +: 8] = 8'(tx_count);
      status[ST_RX_FULL]     = rx_full;
      status[ST_RX_EMPTY]    = rx_empty;
      status[ST_TX_FULL]     = tx_full;
      status[ST_TX_EMPTY]    = tx_empty;
   end
`ifdef WB_MAILBOX_IRQ_EN
   logic [1:0] irq_en_q, irq_en_d;
   logic       irq_q;
   assign irq = irq_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         irq_en_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= (irq_en_q[0] & !rx_empty) | (irq_en_q[1] & tx_empty);
      end
`else
   assign irq = 1'b0;
`endif
   // Every accepted request yields exactly one of ack/err; dat_o is zero unless a read acks
   always_comb begin
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_d   = '0;
      tx_push = 1'b0;
      rx_pop  = 1'b0;
`ifdef WB_MAILBOX_IRQ_EN
      irq_en_d = irq_en_q;
`endif
      if (req)
         case (reg_sel)
            REG_TXDATA: begin
               tx_push = wb.we & !tx_full;
               ack_d   = tx_push;
               err_d   = !tx_push;
            end
            REG_RXDATA: begin
               rx_pop = !wb.we & !rx_empty;
               ack_d  = rx_pop;
               err_d  = !rx_pop;
               dat_d  = rx_pop ? rx_head : '0;
            end
            REG_STATUS: begin
               ack_d = !wb.we;
               err_d = wb.we;
               dat_d = wb.we ? '0 : status;
            end
            default: begin
               ack_d = 1'b1;
`ifdef WB_MAILBOX_IRQ_EN
               if (wb.we) irq_en_d = wb.dat_i[1:0];
               else dat_d = WIDTH'(irq_en_q);
`endif
            end
         endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= ack_d;
         err_q <= err_d;
         dat_q <= dat_d;
      end
endmodule

// File: tb/tb_wb_mailbox.sv
// tb_wb_mailbox: directed self-checking bench for wb_mailbox (DEPTH=8)
module tb_wb_mailbox;
   logic        clk;
   logic        rst;
   logic        tx_valid;
   logic [31:0] tx_data;
   logic        tx_ready;
   logic        rx_valid;
   logic [31:0] rx_data;
   logic        rx_ready;
   logic        irq;
   int          errors;
   int          checks;
   wb_if bus ();
   wb_mailbox #(.DEPTH(8), .WIDTH(32)) dut (
      .clk(clk), .rst(rst), .wb(bus),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .irq(irq)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = adr; bus.dat_i = dat; bus.sel = 4'hF;
      @(posedge clk); #1;
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
   endtask
   task automatic rx_push(input logic [31:0] d);
      rx_valid = 1'b1; rx_data = d;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.ack !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_resp: ack=%b err=%b want 0 0", bus.ack, bus.err); end
      checks++; if (bus.dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", bus.dat_o); end
      checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL reset_flags: tx_valid=%b rx_ready=%b irq=%b want 0 1 0", tx_valid, rx_ready, irq); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      rst = 1'b0;
      xfer(1'b0, 32'h8, 32'h0);
      checks++; if (bus.ack !== 1'b1 || bus.dat_o !== 32'h5) begin errors++; $display("FAIL reset_status: ack=%b dat=%h want 1 00000005", bus.ack, bus.dat_o); end
      xfer(1'b0, 32'hC, 32'h0);
      checks++; if (bus.ack !== 1'b1 || bus.dat_o !== 32'h0) begin errors++; $display("FAIL reset_irq_en: ack=%b dat=%h want 1 0", bus.ack, bus.dat_o); end
   endtask
   task automatic test_tx_write();
      do_reset();
      xfer(1'b1, 32'h0, 32'hDEADBEEF);
      checks++; if (bus.ack !== 1'b1 || bus.err !== 1'b0 || bus.dat_o !== 32'h0) begin errors++; $display("FAIL tx_write_resp: ack=%b err=%b dat=%h want 1 0 0", bus.ack, bus.err, bus.dat_o); end
      checks++; if (tx_valid !== 1'b1 || tx_data !== 32'hDEADBEEF) begin errors++; $display("FAIL tx_write_head: valid=%b data=%h want 1 deadbeef", tx_valid, tx_data); end
      xfer(1'b0, 32'h8, 32'h0);
      checks++; if (bus.dat_o !== 32'h104) begin errors++; $display("FAIL tx_write_status: got %h want 00000104", bus.dat_o); end
      @(posedge clk); #1;
      checks++; if (bus.ack !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: ack=%b err=%b want 0 0", bus.ack, bus.err); end
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_pop: valid=%b want 0", tx_valid); end
   endtask
   task automatic test_tx_full();
      do_reset();
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h0; bus.sel = 4'hF;
      for (int i = 0; i < 9; i++) begin
         bus.dat_i = 32'hA0 + i;
         @(posedge clk); #1;
         checks++; if (bus.ack !== (i < 8) || bus.err !== (i == 8)) begin errors++; $display("FAIL tx_b2b_%0d: ack=%b err=%b want %b %b", i, bus.ack, bus.err, i < 8, i == 8); end
      end
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
      xfer(1'b0, 32'h8, 32'h0);
      checks++; if (bus.dat_o !== 32'h806) begin errors++; $display("FAIL tx_full_status: got %h want 00000806", bus.dat_o); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (tx_valid !== 1'b1 || tx_data !== 32'hA0 + i) begin errors++; $display("FAIL tx_drain_%0d: valid=%b data=%h want 1 %h", i, tx_valid, tx_data, 32'hA0 + i); end
         tx_ready = 1'b1;
         @(posedge clk); #1;
      end
      tx_ready = 1'b0;
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: valid=%b want 0", tx_valid); end
   endtask
   task automatic test_rx_read();
      do_reset();
      rx_push(32'h11);
      rx_push(32'h22);
      xfer(1'b0, 32'h4, 32'h0);
      checks++; if (bus.ack !== 1'b1 || bus.dat_o !== 32'h11) begin errors++; $display("FAIL rx_read0: ack=%b dat=%h want 1 11", bus.ack, bus.dat_o); end
      xfer(1'b0, 32'h4, 32'h0);
      checks++; if (bus.ack !== 1'b1 || bus.dat_o !== 32'h22) begin errors++; $display("FAIL rx_read1: ack=%b dat=%h want 1 22", bus.ack, bus.dat_o); end
      xfer(1'b0, 32'h4, 32'h0);
      checks++; if (bus.ack !== 1'b0 || bus.err !== 1'b1 || bus.dat_o !== 32'h0) begin errors++; $display("FAIL rx_read_empty: ack=%b err=%b dat=%h want 0 1 0", bus.ack, bus.err, bus.dat_o); end
   endtask
   task automatic test_rx_simul();
      do_reset();
      for (int i = 0; i < 8; i++) rx_push(32'h100 + i);
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b want 0", rx_ready); end
      rx_valid = 1'b1; rx_data = 32'hFFFF;
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h4;
      #1;
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_simul_ready: got %b want 0", rx_ready); end
      @(posedge clk); #1;
      rx_valid = 1'b0; bus.cyc = 1'b0; bus.stb = 1'b0;
      checks++; if (bus.ack !== 1'b1 || bus.dat_o !== 32'h100) begin errors++; $display("FAIL rx_simul_read: ack=%b dat=%h want 1 100", bus.ack, bus.dat_o); end
      xfer(1'b0, 32'h8, 32'h0);
      checks++; if (bus.dat_o !== 32'h00070001) begin errors++; $display("FAIL rx_simul_status: got %h want 00070001", bus.dat_o); end
      for (int i = 1; i < 8; i++) begin
         xfer(1'b0, 32'h4, 32'h0);
         checks++; if (bus.ack !== 1'b1 || bus.dat_o !== 32'h100 + i) begin errors++; $display("FAIL rx_drain_%0d: ack=%b dat=%h want 1 %h", i, bus.ack, bus.dat_o, 32'h100 + i); end
      end
      xfer(1'b0, 32'h4, 32'h0);
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL rx_no_push_when_full: err=%b want 1", bus.err); end
   endtask
   task automatic test_bad_access();
      do_reset();
      xfer(1'b1, 32'h4, 32'h1234);
      checks++; if (bus.err !== 1'b1 || bus.ack !== 1'b0 || bus.dat_o !== 32'h0) begin errors++; $display("FAIL wr_rxdata: ack=%b err=%b dat=%h want 0 1 0", bus.ack, bus.err, bus.dat_o); end
      xfer(1'b1, 32'h8, 32'hFFFFFFFF);
      checks++; if (bus.err !== 1'b1 || bus.ack !== 1'b0) begin errors++; $display("FAIL wr_status: ack=%b err=%b want 0 1", bus.ack, bus.err); end
      xfer(1'b0, 32'hFFFFFFFA, 32'h0);
      checks++; if (bus.ack !== 1'b1 || bus.dat_o !== 32'h5) begin errors++; $display("FAIL alias_status: ack=%b dat=%h want 1 00000005", bus.ack, bus.dat_o); end
      xfer(1'b1, 32'h00000013, 32'h5A5A5A5A);
      checks++; if (bus.ack !== 1'b1 || tx_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL alias_txdata: ack=%b data=%h want 1 5a5a5a5a", bus.ack, tx_data); end
   endtask
   task automatic test_cyc_low();
      do_reset();
      bus.cyc = 1'b0; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h0; bus.dat_i = 32'h77;
      @(posedge clk); #1;
      bus.stb = 1'b0; bus.we = 1'b0;
      checks++; if (bus.ack !== 1'b0 || bus.err !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL cyc_low: ack=%b err=%b tx_valid=%b want 0 0 0", bus.ack, bus.err, tx_valid); end
   endtask
   task automatic test_back_to_back();
      do_reset();
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h0; bus.dat_i = 32'h1234;
      @(posedge clk); #1;
      bus.we = 1'b0; bus.adr = 32'h8;
      checks++; if (bus.ack !== 1'b1 || bus.dat_o !== 32'h0) begin errors++; $display("FAIL b2b_write: ack=%b dat=%h want 1 0", bus.ack, bus.dat_o); end
      @(posedge clk); #1;
      bus.cyc = 1'b0; bus.stb = 1'b0;
      checks++; if (bus.ack !== 1'b1 || bus.dat_o !== 32'h104) begin errors++; $display("FAIL b2b_status: ack=%b dat=%h want 1 00000104", bus.ack, bus.dat_o); end
   endtask
   task automatic test_irq();
      do_reset();
      xfer(1'b1, 32'hC, 32'h1);
      checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL irq_en_write: ack=%b want 1", bus.ack); end
`ifdef WB_MAILBOX_IRQ_EN
      xfer(1'b0, 32'hC, 32'h0);
      checks++; if (bus.dat_o !== 32'h1 || irq !== 1'b0) begin errors++; $display("FAIL irq_en_read: dat=%h irq=%b want 1 0", bus.dat_o, irq); end
      rx_push(32'h55);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b want 0", irq); end
      @(posedge clk); #1;
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", irq); end
      xfer(1'b0, 32'h4, 32'h0);
      checks++; if (bus.dat_o !== 32'h55 || irq !== 1'b1) begin errors++; $display("FAIL irq_read: dat=%h irq=%b want 55 1", bus.dat_o, irq); end
      @(posedge clk); #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", irq); end
      xfer(1'b1, 32'hC, 32'h2);
      @(posedge clk); #1;
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty: got %b want 1", irq); end
`else
      xfer(1'b0, 32'hC, 32'h0);
      checks++; if (bus.ack !== 1'b1 || bus.dat_o !== 32'h0) begin errors++; $display("FAIL irq_en_read: ack=%b dat=%h want 1 0", bus.ack, bus.dat_o); end
      rx_push(32'h55);
      @(posedge clk); @(posedge clk); #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied: got %b want 0", irq); end
`endif
   endtask
   task automatic test_reset_mid();
      do_reset();
      rx_push(32'h77);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h4;
      @(posedge clk); #1;
      rst = 1'b1; bus.cyc = 1'b0; bus.stb = 1'b0;
      #1;
      checks++; if (bus.ack !== 1'b0 || bus.dat_o !== 32'h0) begin errors++; $display("FAIL rst_mid_drop: ack=%b dat=%h want 0 0", bus.ack, bus.dat_o); end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.ack !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL rst_mid_after: ack=%b err=%b want 0 0", bus.ack, bus.err); end
      xfer(1'b0, 32'h8, 32'h0);
      checks++; if (bus.ack !== 1'b1 || bus.dat_o !== 32'h5) begin errors++; $display("FAIL rst_mid_status: ack=%b dat=%h want 1 00000005", bus.ack, bus.dat_o); end
   endtask
   initial begin
      errors = 0; checks = 0;
      rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.sel = '0; bus.dat_i = '0;
      test_reset();
      test_tx_write();
      test_tx_full();
      test_rx_read();
      test_rx_simul();
      test_bad_access();
      test_cyc_low();
      test_back_to_back();
      test_irq();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
